// File: rtl/native_master_pkg.sv
// native_master_pkg -- shared types and constants for native_reg_master.
//   sel_e     : target select encoding carried on req_sel
//   state_e   : command FSM states
//   STAT_*    : STATUS word bit offsets, relative to the end of the
//               fifo_word_count field (which occupies the LSBs)
//   req_t     : captured command fields (address kept separate: width is a
//               module parameter)
//   cfg_word  : packs CONFIG readback bits into a 32-bit word
package native_master_pkg;

  typedef enum logic [2:0] {
    SEL_COUNT  = 3'd0,
    SEL_CONFIG = 3'd1,
    SEL_STATUS = 3'd2,
    SEL_FIFO   = 3'd3,
    SEL_MEM    = 3'd4,
    SEL_IRQCLR = 3'd5
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WAIT,
    ST_RESP
  } state_e;

  // STATUS = {zeros, irq_pending, fifo_full, fifo_empty, lt_1k, word_count}
  localparam int STAT_LT1K_OFS  = 0;
  localparam int STAT_EMPTY_OFS = 1;
  localparam int STAT_FULL_OFS  = 2;
  localparam int STAT_IRQ_OFS   = 3;

  typedef struct packed {
    logic        write;
    logic [2:0]  sel;
    logic [31:0] wdata;
  } req_t;

  function automatic logic [31:0] cfg_word(input logic en, input logic dir,
                                           input logic ire);
    return {29'd0, ire, dir, en};
  endfunction

endpackage

// File: rtl/native_irq_latch.sv
// native_irq_latch -- rising-edge detector feeding a sticky pending flag.
// Only compiled when NATIVE_MASTER_IRQ_LATCH_EN is defined, which is also the
// only build that instantiates it.
//   clk, reset  : clock, synchronous active-low reset
//   irq_in      : raw peripheral interrupt level
//   clr         : one-cycle clear request (IRQCLR write)
//   irq_pending : sticky flag; a rising edge in the clear cycle wins
`ifdef NATIVE_MASTER_IRQ_LATCH_EN
module native_irq_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic clr,
  output logic irq_pending
);

  logic r_irq_q;
  logic r_pending;
  logic w_rise;

  assign w_rise      = irq_in & ~r_irq_q;
  assign irq_pending = r_pending;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq_q   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_irq_q <= irq_in;
      // set has priority so an edge arriving with the clear is not lost
      if (w_rise)   r_pending <= 1'b1;
      else if (clr) r_pending <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/native_reg_master.sv
// native_reg_master -- single-outstanding command master that turns a
// valid/ready request into strobes on a set of native peripheral ports
// (counter, config, FIFO, memory, interrupt) and returns a response.
//   clk, reset           : clock, synchronous active-low reset
//   req_*                : command channel (write, sel, addr, wdata)
//   rsp_*                : response channel (rdata, err)
//   count_*              : counter load / readback
//   config_we, *_in/_out : config load / readback, lt_1k_out status
//   fifo_*               : FIFO push/pop strobes, data and flags
//   mem_*                : synchronous memory port (1-cycle read latency)
//   irq_in, irq_pending  : interrupt input and status
// Optional feature: define NATIVE_MASTER_IRQ_LATCH_EN for a sticky,
// edge-triggered irq_pending cleared by an IRQCLR write. Without it,
// irq_pending is irq_in delayed one cycle and IRQCLR responds with an error.
module native_reg_master
  import native_master_pkg::*;
#(
  parameter int MEM_AW  = 8,
  parameter int FIFO_CW = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [2:0]         req_sel,
  input  logic [MEM_AW-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic               count_we,
  output logic [31:0]        count_in,
  input  logic [31:0]        count_out,
  output logic               config_we,
  output logic               en_in,
  output logic               dir_in,
  output logic               ire_in,
  input  logic               en_out,
  input  logic               dir_out,
  input  logic               ire_out,
  input  logic               lt_1k_out,
  output logic               fifo_we,
  output logic               fifo_re,
  output logic [7:0]         fifo_data_in,
  input  logic [7:0]         fifo_data_out,
  input  logic [FIFO_CW-1:0] fifo_word_count,
  input  logic               fifo_empty,
  input  logic               fifo_full,
  output logic               mem_write_en,
  output logic [MEM_AW-1:0]  mem_address,
  output logic [31:0]        mem_data_in,
  input  logic [31:0]        mem_data_out,
  input  logic               irq_in,
  output logic               irq_pending
);

  state_e            r_state, w_state_n;
  req_t              r_req;
  logic [MEM_AW-1:0] r_addr;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic        w_count_we, w_config_we, w_fifo_we, w_fifo_re, w_mem_we;
  logic [31:0] w_ex_rdata;
  logic        w_ex_err;
  logic [31:0] w_status;
  logic        w_irq_pending;

  // ---------------- interrupt status ----------------
`ifdef NATIVE_MASTER_IRQ_LATCH_EN
  logic w_irq_clr;

  native_irq_latch u_irq_latch (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .clr         (w_irq_clr & reset),
    .irq_pending (w_irq_pending)
  );
`else
  logic r_irq_pending;

  always_ff @(posedge clk) begin
    if (!reset) r_irq_pending <= 1'b0;
    else        r_irq_pending <= irq_in;
  end

  assign w_irq_pending = r_irq_pending;
`endif

  assign irq_pending = w_irq_pending;

  // ---------------- STATUS word ----------------
  always_comb begin
    w_status                                = '0;
    w_status[FIFO_CW-1:0]                   = fifo_word_count;
    w_status[FIFO_CW + STAT_LT1K_OFS]       = lt_1k_out;
    w_status[FIFO_CW + STAT_EMPTY_OFS]      = fifo_empty;
    w_status[FIFO_CW + STAT_FULL_OFS]       = fifo_full;
    w_status[FIFO_CW + STAT_IRQ_OFS]        = w_irq_pending;
  end

  // ---------------- FSM state register ----------------
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  // ---------------- FSM next state + EXEC decode ----------------
  always_comb begin
    w_state_n   = r_state;
    w_count_we  = 1'b0;
    w_config_we = 1'b0;
    w_fifo_we   = 1'b0;
    w_fifo_re   = 1'b0;
    w_mem_we    = 1'b0;
`ifdef NATIVE_MASTER_IRQ_LATCH_EN
    w_irq_clr   = 1'b0;
`endif
    w_ex_rdata  = '0;
    w_ex_err    = 1'b0;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_n = ST_EXEC;
      ST_EXEC: begin
        w_state_n = ST_RESP;
        case (r_req.sel)
          SEL_COUNT: begin
            if (r_req.write) w_count_we = 1'b1;
            else             w_ex_rdata = count_out;
          end
          SEL_CONFIG: begin
            if (r_req.write) w_config_we = 1'b1;
            else             w_ex_rdata  = cfg_word(en_out, dir_out, ire_out);
          end
          SEL_STATUS: begin
            if (r_req.write) w_ex_err   = 1'b1;
            else             w_ex_rdata = w_status;
          end
          SEL_FIFO: begin
            // full/empty turn the access into an error with no strobe
            if (r_req.write) begin
              if (fifo_full) w_ex_err  = 1'b1;
              else           w_fifo_we = 1'b1;
            end else begin
              if (fifo_empty) w_ex_err = 1'b1;
              else begin
                w_fifo_re = 1'b1;
                w_state_n = ST_WAIT;
              end
            end
          end
          SEL_MEM: begin
            if (r_req.write) w_mem_we  = 1'b1;
            else             w_state_n = ST_WAIT;
          end
          SEL_IRQCLR: begin
`ifdef NATIVE_MASTER_IRQ_LATCH_EN
            if (r_req.write) w_irq_clr = 1'b1;
            else             w_ex_err  = 1'b1;
`else
            w_ex_err = 1'b1;
`endif
          end
          default: w_ex_err = 1'b1;
        endcase
      end
      ST_WAIT: w_state_n = ST_RESP;
      ST_RESP: if (rsp_ready) w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  // ---------------- command capture / response data ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_req   <= '0;
      r_addr  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (req_valid) begin
          r_req.write <= req_write;
          r_req.sel   <= req_sel;
          r_req.wdata <= req_wdata;
          r_addr      <= req_addr;
        end
        ST_EXEC: begin
          r_rdata <= w_ex_rdata;
          r_err   <= w_ex_err;
        end
        // read data is valid the cycle after address / fifo_re
        ST_WAIT: begin
          if (r_req.sel == SEL_MEM) r_rdata <= mem_data_out;
          else                      r_rdata <= {24'd0, fifo_data_out};
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // strobes are also masked by reset so a reset landing on EXEC cannot pulse
  assign count_we     = w_count_we  & reset;
  assign config_we    = w_config_we & reset;
  assign fifo_we      = w_fifo_we   & reset;
  assign fifo_re      = w_fifo_re   & reset;
  assign mem_write_en = w_mem_we    & reset;

  assign count_in     = r_req.wdata;
  assign en_in        = r_req.wdata[0];
  assign dir_in       = r_req.wdata[1];
  assign ire_in       = r_req.wdata[2];
  assign fifo_data_in = r_req.wdata[7:0];
  assign mem_address  = r_addr;
  assign mem_data_in  = r_req.wdata;

endmodule
